// File: rtl/microwave_cook_controller.sv
// Microwave cook sequencer.
// Loads a BCD M:SS time from the keypad block and counts it down on the 1 Hz tick.
// Start, stop/pause, clear and the door switch control the cook cycle.
// A done indication is held for DONE_TICKS ticks after the count reaches 0:00.
//
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   tick_1hz                     one-cycle pulse, once per second
//   startn, stopn, clearn        debounced front-panel buttons, active-low levels
//   door_closed                  1 = door closed
//   key_loadn, key_*             time entered on the keypad (valid when key_loadn = 1)
//   keypad_enablen               keypad enable; 0 clears and holds the keypad
//   mag_on, done                 magnetron enable, cook-complete indication
//   disp_*                       displayed digits
//   state                        0 IDLE, 1 COOKING, 2 PAUSED, 3 DONE
module microwave_cook_controller #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_loadn,
    input  logic [3:0] key_sec_ones,
    input  logic [3:0] key_sec_tens,
    input  logic [3:0] key_min_ones,
    output logic       keypad_enablen,
    output logic       mag_on,
    output logic       done,
    output logic [3:0] disp_sec_ones,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_min_ones,
    output logic [1:0] state
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DIG_W-1:0]   so_q, so_d;
    logic [DIG_W-1:0]   st_q, st_d;
    logic [DIG_W-1:0]   mo_q, mo_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic               start_hist_q, stop_hist_q, clear_hist_q;
    logic               mag_on_d, done_d, keypad_enablen_d;
    logic [DIG_W-1:0]   disp_so_d, disp_st_d, disp_mo_d;

    logic               start_ev, stop_ev, clear_ev;
    logic               time_valid;
    logic [DIG_W-1:0]   dec_so, dec_st, dec_mo;
    logic               dec_zero;

    // Press events: released on the previous edge, pressed on this one.
    assign start_ev = start_hist_q & ~startn;
    assign stop_ev  = stop_hist_q  & ~stopn;
    assign clear_ev = clear_hist_q & ~clearn;

    // Entered time must be a legal, non-zero M:SS value.
    assign time_valid = key_loadn
                      && (key_sec_ones <= DIG_W'(9))
                      && (key_sec_tens <= DIG_W'(5))
                      && (key_min_ones <= DIG_W'(9))
                      && ((key_sec_ones | key_sec_tens | key_min_ones) != '0);

    // One-second BCD decrement of the countdown with borrow chain.
    always_comb begin
        dec_so = so_q;
        dec_st = st_q;
        dec_mo = mo_q;
        if (so_q != '0) begin
            dec_so = so_q - DIG_W'(1);
        end else begin
            dec_so = DIG_W'(9);
            if (st_q != '0) begin
                dec_st = st_q - DIG_W'(1);
            end else begin
                dec_st = DIG_W'(5);
                dec_mo = mo_q - DIG_W'(1);
            end
        end
    end

    assign dec_zero = (dec_so == '0) && (dec_st == '0) && (dec_mo == '0);

    // Next-state, countdown and output logic.
    always_comb begin
        state_d    = state_q;
        so_d       = so_q;
        st_d       = st_q;
        mo_d       = mo_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (clear_ev) begin
                    state_d = ST_IDLE;
                end else if (start_ev && time_valid && door_closed) begin
                    so_d    = key_sec_ones;
                    st_d    = key_sec_tens;
                    mo_d    = key_min_ones;
                    state_d = ST_COOKING;
                end
            end
            ST_COOKING: begin
                if (clear_ev) begin
                    so_d    = '0;
                    st_d    = '0;
                    mo_d    = '0;
                    state_d = ST_IDLE;
                end else if (stop_ev || !door_closed) begin
                    state_d = ST_PAUSED;
                end else if (tick_1hz) begin
                    so_d = dec_so;
                    st_d = dec_st;
                    mo_d = dec_mo;
                    if (dec_zero) begin
                        done_cnt_d = '0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_PAUSED: begin
                if (clear_ev) begin
                    so_d    = '0;
                    st_d    = '0;
                    mo_d    = '0;
                    state_d = ST_IDLE;
                end else if (stop_ev || !door_closed) begin
                    state_d = ST_PAUSED;
                end else if (start_ev) begin
                    state_d = ST_COOKING;
                end
            end
            ST_DONE: begin
                // Door opening is deliberately ignored here.
                if (clear_ev || stop_ev) begin
                    done_cnt_d = '0;
                    so_d       = '0;
                    st_d       = '0;
                    mo_d       = '0;
                    state_d    = ST_IDLE;
                end else if (tick_1hz) begin
                    if (done_cnt_q == CNT_W'(DONE_TICKS - 1)) begin
                        done_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        done_cnt_d = done_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mag_on_d         = (state_d == ST_COOKING);
        done_d           = (state_d == ST_DONE);
        // A clear always drops the keypad enable for one cycle so the keypad is wiped.
        keypad_enablen_d = (state_d == ST_IDLE) && !clear_ev;

        if (state_d == ST_IDLE) begin
            disp_so_d = key_sec_ones;
            disp_st_d = key_sec_tens;
            disp_mo_d = key_min_ones;
        end else begin
            disp_so_d = so_d;
            disp_st_d = st_d;
            disp_mo_d = mo_d;
        end
    end

    // State, countdown, button history and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            so_q           <= '0;
            st_q           <= '0;
            mo_q           <= '0;
            done_cnt_q     <= '0;
            start_hist_q   <= 1'b1;
            stop_hist_q    <= 1'b1;
            clear_hist_q   <= 1'b1;
            mag_on         <= 1'b0;
            done           <= 1'b0;
            keypad_enablen <= 1'b0;
            disp_sec_ones  <= '0;
            disp_sec_tens  <= '0;
            disp_min_ones  <= '0;
        end else begin
            state_q        <= state_d;
            so_q           <= so_d;
            st_q           <= st_d;
            mo_q           <= mo_d;
            done_cnt_q     <= done_cnt_d;
            start_hist_q   <= startn;
            stop_hist_q    <= stopn;
            clear_hist_q   <= clearn;
            mag_on         <= mag_on_d;
            done           <= done_d;
            keypad_enablen <= keypad_enablen_d;
            disp_sec_ones  <= disp_so_d;
            disp_sec_tens  <= disp_st_d;
            disp_min_ones  <= disp_mo_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_microwave_cook_controller.sv
// Directed self-checking bench for microwave_cook_controller (DONE_TICKS = 3).
module tb_microwave_cook_controller;

    logic       clk;
    logic       rstn;
    logic       tick_1hz;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_loadn;
    logic [3:0] key_sec_ones;
    logic [3:0] key_sec_tens;
    logic [3:0] key_min_ones;
    logic       keypad_enablen;
    logic       mag_on;
    logic       done;
    logic [3:0] disp_sec_ones;
    logic [3:0] disp_sec_tens;
    logic [3:0] disp_min_ones;
    logic [1:0] state;
    logic [11:0] disp;

    int n_checks = 0;
    int n_errors = 0;

    microwave_cook_controller #(.DONE_TICKS(3)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .tick_1hz       (tick_1hz),
        .startn         (startn),
        .stopn          (stopn),
        .clearn         (clearn),
        .door_closed    (door_closed),
        .key_loadn      (key_loadn),
        .key_sec_ones   (key_sec_ones),
        .key_sec_tens   (key_sec_tens),
        .key_min_ones   (key_min_ones),
        .keypad_enablen (keypad_enablen),
        .mag_on         (mag_on),
        .done           (done),
        .disp_sec_ones  (disp_sec_ones),
        .disp_sec_tens  (disp_sec_tens),
        .disp_min_ones  (disp_min_ones),
        .state          (state)
    );

    assign disp = {disp_min_ones, disp_sec_tens, disp_sec_ones};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] mo, input logic [3:0] st, input logic [3:0] so);
        key_min_ones = mo;
        key_sec_tens = st;
        key_sec_ones = so;
    endtask

    // One tick pulse followed by a quiet cycle.
    task automatic tick();
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        step(1);
    endtask

    // 0 = start, 1 = stop, 2 = clear; a quiet cycle first so the press is a fresh edge.
    task automatic press(input int which);
        step(1);
        case (which)
            0: startn = 1'b0;
            1: stopn  = 1'b0;
            default: clearn = 1'b0;
        endcase
        step(1);
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        tick_1hz    = 1'b0;
        startn      = 1'b0;
        stopn       = 1'b1;
        clearn      = 1'b1;
        door_closed = 1'b1;
        key_loadn   = 1'b1;
        set_keys(4'd0, 4'd0, 4'd3);

        // Reset with start held low
        step(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_mag", 32'(mag_on), 32'd0);
        check("rst_kpen", 32'(keypad_enablen), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_disp", 32'(disp), 32'h000);
        rstn   = 1'b1;
        startn = 1'b1;
        step(5);
        check("idle_state", 32'(state), 32'd0);
        check("idle_mag", 32'(mag_on), 32'd0);
        check("idle_kpen", 32'(keypad_enablen), 32'd1);
        check("idle_disp", 32'(disp), 32'h003);

        // 0:03 full cook and done hold
        press(0);
        check("c3_state", 32'(state), 32'd1);
        check("c3_mag", 32'(mag_on), 32'd1);
        check("c3_kpen", 32'(keypad_enablen), 32'd0);
        check("c3_disp", 32'(disp), 32'h003);
        tick();
        check("c3_t1", 32'(disp), 32'h002);
        tick();
        check("c3_t2", 32'(disp), 32'h001);
        tick();
        check("c3_t3_disp", 32'(disp), 32'h000);
        check("c3_t3_state", 32'(state), 32'd3);
        check("c3_t3_done", 32'(done), 32'd1);
        check("c3_t3_mag", 32'(mag_on), 32'd0);
        tick();
        check("d_t1_state", 32'(state), 32'd3);
        check("d_t1_done", 32'(done), 32'd1);
        tick();
        check("d_t2_done", 32'(done), 32'd1);
        tick();
        check("d_t3_state", 32'(state), 32'd0);
        check("d_t3_done", 32'(done), 32'd0);
        check("d_t3_kpen", 32'(keypad_enablen), 32'd1);

        // 1:00 borrow through both second digits, then clear from cooking
        set_keys(4'd1, 4'd0, 4'd0);
        press(0);
        check("m1_state", 32'(state), 32'd1);
        tick();
        check("m1_t1", 32'(disp), 32'h059);
        step(1);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        check("m1_clr_state", 32'(state), 32'd0);
        check("m1_clr_kpen", 32'(keypad_enablen), 32'd0);
        check("m1_clr_mag", 32'(mag_on), 32'd0);
        step(1);
        check("m1_clr_kpen2", 32'(keypad_enablen), 32'd1);

        // 0:10 borrow from tens
        set_keys(4'd0, 4'd1, 4'd0);
        press(0);
        tick();
        check("s10_t1", 32'(disp), 32'h009);
        press(2);
        check("s10_clr", 32'(state), 32'd0);

        // Door-open pause at 0:45
        set_keys(4'd0, 4'd4, 4'd5);
        press(0);
        check("p_cook", 32'(state), 32'd1);
        door_closed = 1'b0;
        step(1);
        check("p_state", 32'(state), 32'd2);
        check("p_mag", 32'(mag_on), 32'd0);
        check("p_disp", 32'(disp), 32'h045);
        tick();
        tick();
        tick();
        check("p_frozen", 32'(disp), 32'h045);
        check("p_state3", 32'(state), 32'd2);
        press(0);
        check("p_start_open", 32'(state), 32'd2);
        door_closed = 1'b1;
        press(0);
        check("p_resume", 32'(state), 32'd1);
        check("p_resume_mag", 32'(mag_on), 32'd1);
        check("p_resume_disp", 32'(disp), 32'h045);
        tick();
        check("p_resume_t1", 32'(disp), 32'h044);

        // Stop and clear together while cooking: clear wins
        set_keys(4'd0, 4'd0, 4'd0);
        step(1);
        stopn  = 1'b0;
        clearn = 1'b0;
        step(1);
        stopn  = 1'b1;
        clearn = 1'b1;
        check("sc_state", 32'(state), 32'd0);
        check("sc_mag", 32'(mag_on), 32'd0);
        check("sc_disp", 32'(disp), 32'h000);
        check("sc_kpen", 32'(keypad_enablen), 32'd0);

        // Invalid starts
        press(0);
        check("inv_zero", 32'(state), 32'd0);
        set_keys(4'd0, 4'd7, 4'd0);
        press(0);
        check("inv_tens", 32'(state), 32'd0);
        set_keys(4'd0, 4'd0, 4'd5);
        door_closed = 1'b0;
        press(0);
        check("inv_door", 32'(state), 32'd0);
        check("inv_door_mag", 32'(mag_on), 32'd0);
        door_closed = 1'b1;
        key_loadn   = 1'b0;
        press(0);
        check("inv_loadn", 32'(state), 32'd0);
        key_loadn = 1'b1;

        // Start coinciding with a tick: the tick is ignored
        set_keys(4'd0, 4'd0, 4'd7);
        step(1);
        startn   = 1'b0;
        tick_1hz = 1'b1;
        step(1);
        startn   = 1'b1;
        tick_1hz = 1'b0;
        check("st_tick_state", 32'(state), 32'd1);
        check("st_tick_disp", 32'(disp), 32'h007);
        tick();
        check("st_tick_t1", 32'(disp), 32'h006);
        press(1);
        check("stop_pause", 32'(state), 32'd2);
        press(1);
        check("stop_in_pause", 32'(state), 32'd2);
        press(2);
        check("clr_pause", 32'(state), 32'd0);

        // Done: door ignored, stop exits immediately
        set_keys(4'd0, 4'd0, 4'd1);
        press(0);
        tick();
        check("dx_state", 32'(state), 32'd3);
        door_closed = 1'b0;
        step(2);
        check("dx_door", 32'(state), 32'd3);
        check("dx_door_done", 32'(done), 32'd1);
        door_closed = 1'b1;
        press(1);
        check("dx_stop_state", 32'(state), 32'd0);
        check("dx_stop_done", 32'(done), 32'd0);

        // Reset mid-cook
        set_keys(4'd0, 4'd0, 4'd5);
        press(0);
        check("rc_cook", 32'(state), 32'd1);
        rstn = 1'b0;
        step(1);
        check("rc_state", 32'(state), 32'd0);
        check("rc_mag", 32'(mag_on), 32'd0);
        check("rc_kpen", 32'(keypad_enablen), 32'd0);
        rstn = 1'b1;
        step(1);
        check("rc_kpen2", 32'(keypad_enablen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
